// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and 8x16 text-cell geometry
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;

    // row*80+col as row*64+row*16+col; 29*80+79 = 2399 fits in 12 bits
    function automatic logic [11:0] cellAddr(input logic [4:0] row, input logic [6:0] col);
        return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical pixel counters and undelayed sync decode
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pixEn,
    output logic [9:0] hCnt,
    output logic [9:0] vCnt,
    output logic       hSyncRaw,
    output logic       vSyncRaw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clock) begin
        if (reset) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (pixEn) begin
            if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? 10'd0 : vCnt + 10'd1;
            end else begin
                hCnt <= hCnt + 10'd1;
            end
        end
    end

    assign hSyncRaw = !((hCnt >= H_SYNC_START) && (hCnt < H_SYNC_END));
    assign vSyncRaw = !((vCnt >= V_SYNC_START) && (vCnt < V_SYNC_END));

endmodule

// File: rtl/char_fetch_ctrl.sv
// rtl/char_fetch_ctrl.sv - text-mode character fetch sequencer and pixel shifter
module char_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixEn,
    output logic [11:0] textAddr,
    input  logic [7:0]  textData,
    output logic [11:0] romAddr,
    input  logic [7:0]  romData,
    output logic        hSync,
    output logic        vSync,
    output logic        blank,
    output logic        outBit,
    output logic        frameStart
);

    localparam logic [2:0] PHASE_TEXT = 3'd0;
    localparam logic [2:0] PHASE_ROM  = 3'd1;
    localparam logic [2:0] PHASE_HOLD = 3'd2;
    localparam logic [2:0] PHASE_LOAD = 3'(CELL_W - 1);

    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic       hSyncRaw;
    logic       vSyncRaw;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) timing (
        .clock    (clock),
        .reset    (reset),
        .pixEn    (pixEn),
        .hCnt     (hCnt),
        .vCnt     (vCnt),
        .hSyncRaw (hSyncRaw),
        .vSyncRaw (vSyncRaw)
    );

    logic [2:0] phase;
    logic [6:0] col;
    logic [4:0] row;
    logic [3:0] glyphLine;
    logic       cellVisible;
    logic       frameOrigin;

    assign phase       = hCnt[2:0];
    assign col         = hCnt[9:3];
    assign row         = vCnt[8:4];
    assign glyphLine   = vCnt[3:0];
    assign cellVisible = (hCnt < 10'(H_ACTIVE)) && (vCnt < 10'(V_ACTIVE));
    assign frameOrigin = (hCnt == 10'd0) && (vCnt == 10'd0);

    logic [7:0] holdReg;
    logic [7:0] shiftReg;
    // Eight-stage delay lines line the sync/blank/origin flags up with the shifter output
    logic [7:0] hSyncDly;
    logic [7:0] vSyncDly;
    logic [7:0] blankDly;
    logic [7:0] originDly;

    always_ff @(posedge clock) begin
        if (reset) begin
            textAddr  <= '0;
            romAddr   <= '0;
            holdReg   <= '0;
            shiftReg  <= '0;
            hSyncDly  <= '1;
            vSyncDly  <= '1;
            blankDly  <= '1;
            originDly <= '0;
        end else if (pixEn) begin
            if (cellVisible) begin
                if (phase == PHASE_TEXT) begin
                    textAddr <= cellAddr(row, col);
                end
                if (phase == PHASE_ROM) begin
                    romAddr <= {textData, glyphLine};
                end
                if (phase == PHASE_HOLD) begin
                    holdReg <= romData;
                end
            end
            if (phase == PHASE_LOAD) begin
                shiftReg <= cellVisible ? holdReg : 8'h00;
            end else begin
                shiftReg <= {shiftReg[6:0], 1'b0};
            end
            hSyncDly  <= {hSyncDly[6:0], hSyncRaw};
            vSyncDly  <= {vSyncDly[6:0], vSyncRaw};
            blankDly  <= {blankDly[6:0], !cellVisible};
            originDly <= {originDly[6:0], frameOrigin};
        end
    end

    assign hSync  = hSyncDly[7];
    assign vSync  = vSyncDly[7];
    assign blank  = blankDly[7];
    assign outBit = shiftReg[7] & ~blankDly[7];
    // A delayed origin tick spans several clocks when pixEn is sparse; only the enabled one pulses
    assign frameStart = originDly[7] & pixEn;

endmodule
